body_renderer: RTL and testbench
================================

# body_renderer

Parametrised multi-body pixel classifier between the NIOS II software and the VGA colour path. Software writes position, radius and enable for up to N_BODIES circles into a shadow register bank and commits; the bank is copied to the active bank at the next vertical-sync start, so a frame is never drawn from half-updated data. For each DrawX/DrawY pixel the block reports whether any enabled body covers it and which one, with fixed pipeline latency. Generalises the single-ball `is_ball` path to many bodies with tear-free updates.

## Interface

- N_BODIES, 8, number of bodies (1..32)
- COORD_W, 10, width of X/Y coordinates and of DrawX/DrawY
- RADIUS_W, 6, width of radius
- IDX_W, $clog2(N_BODIES) (min 1), body index width (derived)

- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe, one shadow field per cycle
- wr_body  in  IDX_W  target body index
- wr_field  in  2  0 = X, 1 = Y, 2 = radius, 3 = enable
- wr_data  in  16  write data, low bits used
- commit  in  1  one-cycle pulse: shadow bank complete
- VGA_VS  in  1  vertical sync, active low, from VGA_controller
- DrawX, DrawY  in  COORD_W  current pixel
- is_ball  out  1  pixel covered by an enabled body
- ball_id  out  IDX_W  lowest-index covering body, 0 when is_ball = 0
- pending  out  1  commit accepted, swap not yet done
- frame_count  out  8  count of VGA_VS falling edges, wraps

## Operation

- Shadow bank per body: x[COORD_W], y[COORD_W], r[RADIUS_W], en[1]. Active bank has the same layout. Only the active bank feeds the pixel datapath.
- Write: wr_en = 1 stores wr_data[COORD_W-1:0] (X, Y), wr_data[RADIUS_W-1:0] (radius) or wr_data[0] (enable) into shadow[wr_body]. A wr_body >= N_BODIES is ignored.
- VS edge: vs_q registers VGA_VS. vs_fall = vs_q & ~VGA_VS. Each vs_fall increments frame_count (mod 256).
- Swap: on vs_fall with pending = 1, active <= shadow (all bodies, one cycle). The shadow bank is kept.
- pending next value = commit | (pending & ~(vs_fall & pending)).
- Simultaneous events:
  - A commit on a swap cycle leaves pending = 1, so the next frame swaps again.
  - A write on a swap cycle updates the shadow bank only. It is not in the active bank until the next swap.
  - A commit with no following VS keeps pending = 1 indefinitely.
- Hit test per body, all bodies in parallel:
  - dx = DrawX − x and dy = DrawY − y, signed, COORD_W+1 bits.
  - hit = en & (dx² + dy² <= r²).
  - Squares are 2·(COORD_W+1) bits and the sum is one bit wider, so there is no overflow.
  - r = 0 hits only the centre pixel.
- Priority: is_ball = OR of hits. ball_id = lowest hit index.
- Active bank contents change only at a swap, never mid-frame.

## Timing

- Pipeline is 2 stages. Stage 1 registers dx, dy and r² per body. Stage 2 registers the compare, priority encode and the outputs.
- DrawX/DrawY sampled at edge k produce is_ball and ball_id valid after edge k+2.
- Throughput is one pixel per Clk. The pipeline is not stalled by writes or swaps.
- A swap at edge s affects pixels sampled from edge s+1 onward.
- pending rises the cycle after commit and falls the cycle after the swapping vs_fall.
- Reset (asynchronous, any time) clears:
  - both banks (all x, y, r, en = 0)
  - the pipeline registers and vs_q (reset to 1)
  - outputs is_ball = 0, ball_id = 0, pending = 0, frame_count = 0
- Reset mid-frame or mid-commit discards any pending swap. The first output after reset release is is_ball = 0 for 2 cycles.

## Test plan

- Reset, then sweep a full frame -> is_ball = 0 everywhere; frame_count = 1 after one VS falling edge; pending = 0.
- Write body 0 as x = 100, y = 100, r = 5, en = 1, then commit, then VS fall:
  - pixels (105,100) and (103,104) -> is_ball = 1, ball_id = 0, 2 cycles after presentation
  - pixels (106,100) and (104,104) -> is_ball = 0
- Write without commit, then VS fall -> active unchanged, old frame still drawn. A later commit plus VS fall -> new data is drawn and pending drops the next cycle.
- Bodies 2 and 5 overlap at (200,200), both enabled -> ball_id = 2. After en2 = 0, commit and VS fall -> ball_id = 5.
- Commit pulse on the same cycle as a swapping vs_fall, plus a write to x of body 1 on that cycle -> swap uses the pre-write shadow; pending stays 1; the next vs_fall makes the new x active.
- Assert Reset while pending = 1 mid-frame -> all outputs 0 immediately; after release, no swap happens at the next VS; 256 VS edges wrap frame_count to 0.

Source files
------------

// File: rtl/body_renderer_if.sv
// Software register-write port, VGA timing/pixel inputs and classifier outputs
// of body_renderer, bundled as one bus.
interface body_renderer_if #(
  parameter int N_BODIES = 8,
  parameter int COORD_W  = 10,
  parameter int RADIUS_W = 6
);
  localparam int IDX_W = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_body;
  logic [1:0]         wr_field;
  logic [15:0]        wr_data;
  logic               commit;
  logic               VGA_VS;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               is_ball;
  logic [IDX_W-1:0]   ball_id;
  logic               pending;
  logic [7:0]         frame_count;

  modport master (
    output wr_en, wr_body, wr_field, wr_data, commit, VGA_VS, DrawX, DrawY,
    input  is_ball, ball_id, pending, frame_count
  );

  modport slave (
    input  wr_en, wr_body, wr_field, wr_data, commit, VGA_VS, DrawX, DrawY,
    output is_ball, ball_id, pending, frame_count
  );
endinterface

// File: rtl/body_renderer.sv
// Multi-body circle classifier: double-buffered body bank swapped at VS start,
// 2-stage per-pixel hit test with lowest-index priority.
module body_renderer_lane #(
  parameter int COORD_W  = 10,
  parameter int RADIUS_W = 6
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                en_i,
  input  logic [COORD_W-1:0]  x_i,
  input  logic [COORD_W-1:0]  y_i,
  input  logic [RADIUS_W-1:0] r_i,
  input  logic [COORD_W-1:0]  draw_x_i,
  input  logic [COORD_W-1:0]  draw_y_i,
  output logic                hit_o
);
  localparam int SQ_W  = 2 * (COORD_W + 1);
  localparam int SUM_W = SQ_W + 1;

  logic signed [COORD_W:0]  dx_d, dy_d, dx_q, dy_q;
  logic [2*RADIUS_W-1:0]    r2_d, r2_q;
  logic                     en_q;
  logic signed [SQ_W-1:0]   dx_w, dy_w;
  logic [SQ_W-1:0]          dx2, dy2;
  logic [SUM_W-1:0]         dist2;

  assign dx_d = $signed({1'b0, draw_x_i}) - $signed({1'b0, x_i});
  assign dy_d = $signed({1'b0, draw_y_i}) - $signed({1'b0, y_i});
  assign r2_d = (2*RADIUS_W)'(r_i) * (2*RADIUS_W)'(r_i);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dx_q <= '0;
      dy_q <= '0;
      r2_q <= '0;
      en_q <= 1'b0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
      r2_q <= r2_d;
      en_q <= en_i;
    end
  end

  // Squares are taken at full width so the sum can never wrap.
  assign dx_w  = {{(SQ_W-COORD_W-1){dx_q[COORD_W]}}, dx_q};
  assign dy_w  = {{(SQ_W-COORD_W-1){dy_q[COORD_W]}}, dy_q};
  assign dx2   = dx_w * dx_w;
  assign dy2   = dy_w * dy_w;
  assign dist2 = SUM_W'(dx2) + SUM_W'(dy2);
  assign hit_o = en_q & (dist2 <= SUM_W'(r2_q));
endmodule

module body_renderer #(
  parameter int N_BODIES = 8,
  parameter int COORD_W  = 10,
  parameter int RADIUS_W = 6
) (
  input logic            Clk,
  input logic            Reset,
  body_renderer_if.slave bus
);
  localparam int IDX_W = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;

  logic [N_BODIES-1:0][COORD_W-1:0]  sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [N_BODIES-1:0][COORD_W-1:0]  act_x_q, act_x_d, act_y_q, act_y_d;
  logic [N_BODIES-1:0][RADIUS_W-1:0] sh_r_q, sh_r_d, act_r_q, act_r_d;
  logic [N_BODIES-1:0]               sh_en_q, sh_en_d, act_en_q, act_en_d;

  logic             vs_q, vs_fall, swap;
  logic             pend_q, pend_d;
  logic [7:0]       frame_q, frame_d;
  logic             wr_ok;
  logic [N_BODIES-1:0] hit;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             is_ball_q;
  logic [IDX_W-1:0] ball_id_q;
  logic             unused_wr_data;

  assign unused_wr_data = ^bus.wr_data;

  if ((1 << IDX_W) > N_BODIES) begin : g_range
    assign wr_ok = bus.wr_en & (32'(bus.wr_body) < 32'(N_BODIES));
  end else begin : g_norange
    assign wr_ok = bus.wr_en;
  end

  assign vs_fall = vs_q & ~bus.VGA_VS;
  assign swap    = vs_fall & pend_q;
  assign pend_d  = bus.commit | (pend_q & ~swap);
  assign frame_d = vs_fall ? frame_q + 8'd1 : frame_q;

  // A write landing on the swap cycle goes to shadow only; the swap copies
  // the pre-write shadow contents.
  always_comb begin
    sh_x_d  = sh_x_q;
    sh_y_d  = sh_y_q;
    sh_r_d  = sh_r_q;
    sh_en_d = sh_en_q;
    if (wr_ok) begin
      case (bus.wr_field)
        2'd0:    sh_x_d[bus.wr_body]  = bus.wr_data[COORD_W-1:0];
        2'd1:    sh_y_d[bus.wr_body]  = bus.wr_data[COORD_W-1:0];
        2'd2:    sh_r_d[bus.wr_body]  = bus.wr_data[RADIUS_W-1:0];
        default: sh_en_d[bus.wr_body] = bus.wr_data[0];
      endcase
    end
  end

  assign act_x_d  = swap ? sh_x_q  : act_x_q;
  assign act_y_d  = swap ? sh_y_q  : act_y_q;
  assign act_r_d  = swap ? sh_r_q  : act_r_q;
  assign act_en_d = swap ? sh_en_q : act_en_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q     <= 1'b1;
      pend_q   <= 1'b0;
      frame_q  <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_r_q   <= '0;
      sh_en_q  <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      act_r_q  <= '0;
      act_en_q <= '0;
    end else begin
      vs_q     <= bus.VGA_VS;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
      sh_x_q   <= sh_x_d;
      sh_y_q   <= sh_y_d;
      sh_r_q   <= sh_r_d;
      sh_en_q  <= sh_en_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      act_r_q  <= act_r_d;
      act_en_q <= act_en_d;
    end
  end

  for (genvar g = 0; g < N_BODIES; g++) begin : g_lane
    body_renderer_lane #(.COORD_W(COORD_W), .RADIUS_W(RADIUS_W)) u_lane (
      .Clk      (Clk),
      .Reset    (Reset),
      .en_i     (act_en_q[g]),
      .x_i      (act_x_q[g]),
      .y_i      (act_y_q[g]),
      .r_i      (act_r_q[g]),
      .draw_x_i (bus.DrawX),
      .draw_y_i (bus.DrawY),
      .hit_o    (hit[g])
    );
  end

  always_comb begin
    hit_any = |hit;
    hit_idx = '0;
    for (int i = N_BODIES - 1; i >= 0; i--)
      if (hit[i]) hit_idx = IDX_W'(i);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_ball_q <= 1'b0;
      ball_id_q <= '0;
    end else begin
      is_ball_q <= hit_any;
      ball_id_q <= hit_idx;
    end
  end

  assign bus.is_ball     = is_ball_q;
  assign bus.ball_id     = ball_id_q;
  assign bus.pending     = pend_q;
  assign bus.frame_count = frame_q;
endmodule

// File: tb/tb_body_renderer.sv
// Randomised and directed check of body_renderer against a per-frame
// behavioural model of the body banks and circle hit rule.
module tb_body_renderer;
  localparam int N     = 8;
  localparam int CW    = 10;
  localparam int RW    = 6;
  localparam int IDX_W = 3;

  typedef struct { int hit; int id; } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  body_renderer_if #(.N_BODIES(N), .COORD_W(CW), .RADIUS_W(RW)) bus();
  body_renderer #(.N_BODIES(N), .COORD_W(CW), .RADIUS_W(RW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int m_sx[N], m_sy[N], m_sr[N], m_se[N];
  int m_ax[N], m_ay[N], m_ar[N], m_ae[N];
  int m_pend, m_fc, m_vs;
  exp_t q[$];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t classify(int px, int py);
    exp_t e;
    e.hit = 0;
    e.id  = 0;
    for (int i = 0; i < N; i++) begin
      int dx = px - m_ax[i];
      int dy = py - m_ay[i];
      if (m_ae[i] != 0 && dx*dx + dy*dy <= m_ar[i]*m_ar[i]) begin
        e.hit = 1;
        e.id  = i;
        return e;
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_sr[i] = 0; m_se[i] = 0;
      m_ax[i] = 0; m_ay[i] = 0; m_ar[i] = 0; m_ae[i] = 0;
    end
    m_pend = 0;
    m_fc   = 0;
    m_vs   = 1;
    q = {};
    q.push_back('{0, 0});
  endtask

  // One clock: the model consumes the inputs present now, then the DUT
  // outputs after the edge are compared with the model.
  task automatic tick();
    exp_t e;
    int   vf, sw, b, d;
    q.push_back(classify(int'(bus.DrawX), int'(bus.DrawY)));
    vf = (m_vs == 1 && bus.VGA_VS == 1'b0) ? 1 : 0;
    sw = vf & m_pend;
    if (sw != 0)
      for (int i = 0; i < N; i++) begin
        m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_ar[i] = m_sr[i]; m_ae[i] = m_se[i];
      end
    if (bus.wr_en) begin
      b = int'(bus.wr_body);
      d = int'(bus.wr_data);
      if (b < N)
        case (int'(bus.wr_field))
          0: m_sx[b] = d % (1 << CW);
          1: m_sy[b] = d % (1 << CW);
          2: m_sr[b] = d % (1 << RW);
          default: m_se[b] = d % 2;
        endcase
    end
    m_pend = (bus.commit || (m_pend != 0 && sw == 0)) ? 1 : 0;
    if (vf != 0) m_fc = (m_fc + 1) % 256;
    m_vs = int'(bus.VGA_VS);
    @(posedge Clk);
    #1;
    e = q.pop_front();
    chk("is_ball", int'(bus.is_ball), e.hit);
    chk("ball_id", int'(bus.ball_id), e.id);
    chk("pending", int'(bus.pending), m_pend);
    chk("frame_count", int'(bus.frame_count), m_fc);
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("rst_is_ball", int'(bus.is_ball), 0);
    chk("rst_ball_id", int'(bus.ball_id), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_frame_count", int'(bus.frame_count), 0);
    model_clear();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wr(int b, int f, int d);
    bus.wr_en    = 1'b1;
    bus.wr_body  = IDX_W'(b);
    bus.wr_field = 2'(f);
    bus.wr_data  = 16'(d);
    tick();
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
  endtask

  task automatic vs_pulse();
    bus.VGA_VS = 1'b0;
    tick();
    bus.VGA_VS = 1'b1;
    tick();
  endtask

  task automatic probe(string tag, int x, int y, int eh, int eid);
    bus.DrawX = CW'(x);
    bus.DrawY = CW'(y);
    tick();
    tick();
    chk(tag, int'(bus.is_ball), eh);
    if (eh != 0) chk(tag, int'(bus.ball_id), eid);
  endtask

  task automatic set_body(int b, int x, int y, int r, int en);
    wr(b, 0, x);
    wr(b, 1, y);
    wr(b, 2, r);
    wr(b, 3, en);
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_body  = '0;
    bus.wr_field = '0;
    bus.wr_data  = '0;
    bus.commit   = 1'b0;
    bus.VGA_VS   = 1'b1;
    bus.DrawX    = '0;
    bus.DrawY    = '0;
    do_reset();

    // empty frame sweep
    for (int i = 0; i < 300; i++) begin
      bus.DrawX = CW'($urandom_range(0, 639));
      bus.DrawY = CW'($urandom_range(0, 479));
      tick();
    end
    vs_pulse();
    chk("first_frame_count", int'(bus.frame_count), 1);
    chk("first_pending", int'(bus.pending), 0);

    // single body, boundary pixels
    set_body(0, 100, 100, 5, 1);
    do_commit();
    vs_pulse();
    probe("edge_105_100", 105, 100, 1, 0);
    probe("edge_103_104", 103, 104, 1, 0);
    probe("out_106_100", 106, 100, 0, 0);
    probe("out_104_104", 104, 104, 0, 0);
    probe("centre_r5", 100, 100, 1, 0);

    // write without commit stays invisible
    wr(0, 0, 300);
    vs_pulse();
    probe("nocommit_old", 105, 100, 1, 0);
    probe("nocommit_new", 300, 100, 0, 0);
    do_commit();
    chk("commit_pending", int'(bus.pending), 1);
    bus.VGA_VS = 1'b0;
    tick();
    chk("swap_pending_drop", int'(bus.pending), 0);
    bus.VGA_VS = 1'b1;
    tick();
    probe("commit_new", 300, 100, 1, 0);
    probe("commit_old", 105, 100, 0, 0);

    // priority between overlapping bodies
    set_body(2, 200, 200, 10, 1);
    set_body(5, 200, 200, 20, 1);
    do_commit();
    vs_pulse();
    probe("prio_both", 200, 200, 1, 2);
    probe("prio_only5", 215, 200, 1, 5);
    wr(2, 3, 0);
    do_commit();
    vs_pulse();
    probe("prio_dis2", 200, 200, 1, 5);

    // r = 0 hits only the centre
    set_body(3, 600, 400, 0, 1);
    do_commit();
    vs_pulse();
    probe("r0_centre", 600, 400, 1, 3);
    probe("r0_next", 601, 400, 0, 0);

    // commit + write on the swapping vs_fall
    set_body(1, 400, 50, 3, 1);
    do_commit();
    vs_pulse();
    do_commit();
    bus.VGA_VS   = 1'b0;
    bus.commit   = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_body  = IDX_W'(1);
    bus.wr_field = 2'd0;
    bus.wr_data  = 16'd420;
    tick();
    chk("simul_pending", int'(bus.pending), 1);
    bus.VGA_VS = 1'b1;
    tick();
    probe("simul_old_x", 400, 50, 1, 1);
    probe("simul_new_x_hidden", 420, 50, 0, 0);
    vs_pulse();
    probe("simul_new_x", 420, 50, 1, 1);
    probe("simul_old_gone", 400, 50, 0, 0);
    chk("simul_pending_clear", int'(bus.pending), 0);

    // randomised traffic
    for (int n = 0; n < 2500; n++) begin
      int op, b, px, py;
      op = int'($urandom_range(0, 99));
      if (op < 15) begin
        bus.wr_en    = 1'b1;
        bus.wr_body  = IDX_W'($urandom_range(0, N - 1));
        bus.wr_field = 2'($urandom_range(0, 3));
        bus.wr_data  = 16'($urandom);
      end else if (op < 20) begin
        bus.commit = 1'b1;
      end
      bus.VGA_VS = ($urandom_range(0, 29) != 0) ? 1'b1 : 1'b0;
      b  = int'($urandom_range(0, N - 1));
      px = m_ax[b] + int'($urandom_range(0, 140)) - 70;
      py = m_ay[b] + int'($urandom_range(0, 140)) - 70;
      if (op >= 95) begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      bus.DrawX = CW'(px);
      bus.DrawY = CW'(py);
      tick();
    end
    bus.VGA_VS = 1'b1;
    tick();

    // reset while a swap is pending and a body is drawn
    set_body(4, 500, 300, 8, 1);
    do_commit();
    vs_pulse();
    wr(0, 3, 0);
    wr(2, 3, 0);
    wr(5, 3, 0);
    wr(1, 3, 0);
    wr(3, 3, 0);
    do_commit();
    vs_pulse();
    set_body(6, 50, 50, 4, 1);
    bus.DrawX = CW'(500);
    bus.DrawY = CW'(300);
    do_commit();
    tick();
    chk("pre_rst_hit", int'(bus.is_ball), 1);
    chk("pre_rst_pending", int'(bus.pending), 1);
    do_reset();
    tick();
    tick();
    chk("post_rst_hit", int'(bus.is_ball), 0);
    vs_pulse();
    chk("post_rst_no_swap", int'(bus.pending), 0);
    probe("post_rst_body6", 50, 50, 0, 0);
    for (int i = 0; i < 255; i++) vs_pulse();
    chk("fc_wrap", int'(bus.frame_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
